fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
- Program-counter and instruction-fetch stage of the rv32i core.
- Consumes the branch-resolution result (`taken`) together with branch/jump qualifiers and target from execute, and keeps the PC.
- Issues one instruction-memory request at a time over a valid/ready handshake and hands the fetched word plus its PC to decode.
- Discards responses made stale by a redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- XLEN, 32, address/instruction width; only 32 supported.

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-high reset
- is_branch  in  1  execute holds a conditional branch this cycle
- is_jump  in  1  execute holds JAL/JALR this cycle
- taken  in  1  branch condition result from branch_gen
- target  in  XLEN  redirect target address
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  fetch address (= pc register)
- imem_rsp_valid  in  1  response word valid, at least 1 cycle after acceptance
- imem_rsp_data  in  XLEN  fetched instruction
- if_valid  out  1  instruction available to decode
- if_ready  in  1  decode accepts instruction
- if_instr  out  XLEN  instruction to decode
- if_pc  out  XLEN  PC of if_instr
- misalign_trap  out  1  misaligned-target trap pulse (optional feature)
- misalign_addr  out  XLEN  offending target (optional feature)

Behaviour:
- redirect = is_jump | (is_branch & taken). When redirect=1, target is valid. Redirect has priority over every other event in the same cycle.
- States: S_IDLE, S_REQ, S_WAIT, S_HOLD. Internal 1-bit kill flag.
- Reset (asynchronous, while rst=1):
  - state=S_IDLE, pc=RESET_PC, kill=0
  - if_instr=0, if_pc=0, misalign_trap=0, misalign_addr=0
  - all valid outputs=0
- S_IDLE: next cycle goes to S_REQ unconditionally. A redirect in S_IDLE loads pc=target.
- S_REQ:
  - imem_req_valid=1, imem_req_addr=pc.
  - Accepted (ready=1) without redirect: go to S_WAIT, kill=0.
  - Accepted with redirect: pc=target, go to S_WAIT, kill=1.
  - Not accepted with redirect: pc=target, stay in S_REQ. Address changes only on redirect.
- S_WAIT:
  - imem_req_valid=0.
  - A redirect sets kill=1 and pc=target.
  - On rsp_valid with kill=1, or with a redirect in the same cycle: discard the word, clear kill, go to S_REQ.
  - Otherwise: if_instr=rsp_data, if_pc=pc, pc=pc+4, go to S_HOLD.
- S_HOLD:
  - if_valid=1; if_instr and if_pc stay stable until the handshake completes.
  - A redirect drops the held word (if_valid=0 next cycle), sets pc=target, and goes to S_REQ, even if if_ready=1 that cycle.
  - if_ready=1 without redirect: go to S_REQ.
- Timing:
  - Minimum latency from request acceptance to if_valid is 2 cycles (1-cycle memory).
  - At most one outstanding request.
  - An rsp_valid outside S_WAIT is ignored.
- Arithmetic: pc+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000. Target bits [1:0] are handled per the optional feature.
- Reset mid-transaction: state returns to S_IDLE. Any response arriving after reset deassertion while in S_IDLE or S_REQ is ignored.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined: a redirect with target[1:0]!=0 does not update pc or state; kill/drop semantics are unchanged. misalign_trap pulses 1 for one cycle (registered, the cycle after the redirect) and misalign_addr=target is held until the next trap.
- Undefined: target[1:0] is forced to 00 on load; misalign_trap and misalign_addr are tied to 0.

Test Plan:
- Reset release, RESET_PC=0x100, memory ready=1 with 1-cycle response -> addresses 0x100, 0x104, 0x108 issued in order; if_pc matches each, if_instr equals the memory word.
- is_branch=1, taken=0, target=0x200 during S_WAIT -> no redirect; next fetch at pc+4.
- is_branch=1, taken=1, target=0x200 while in S_WAIT at 0x104 -> response for 0x104 discarded (if_valid never 1 for it); next request address is 0x200.
- is_jump=1, target=0x40 while in S_HOLD with if_ready=1 -> held word not consumed (no if_valid & if_ready handshake); next request is 0x40.
- if_ready=0 for 5 cycles in S_HOLD -> if_valid, if_instr, if_pc stable; no new imem_req_valid; pc at 0xFFFF_FFFC then wraps to 0x0.
- With FETCH_MISALIGN_TRAP_EN, jump to 0x202 -> misalign_trap=1 for exactly one cycle, misalign_addr=0x202, pc unchanged. Without the macro -> fetch at 0x200, trap stays 0.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: rv32i PC register and single-outstanding instruction fetch stage.
// Optional FETCH_MISALIGN_TRAP_EN: trap misaligned redirect targets instead of masking bits [1:0].
module fetch_pc_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            is_branch,
    input  logic            is_jump,
    input  logic            taken,
    input  logic [XLEN-1:0] target,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic            misalign_trap,
    output logic [XLEN-1:0] misalign_addr
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            kill_q, kill_d;
    logic [XLEN-1:0] if_instr_q, if_instr_d;
    logic [XLEN-1:0] if_pc_q, if_pc_d;
    logic            redirect;
    logic            load;
    logic [XLEN-1:0] tgt;

    assign redirect = is_jump | (is_branch & taken);

`ifdef FETCH_MISALIGN_TRAP_EN
    logic            bad;
    logic            trap_q, trap_d;
    logic [XLEN-1:0] maddr_q, maddr_d;

    // A misaligned redirect still kills/drops in-flight work; only the PC load is suppressed.
    always_comb begin
        bad     = redirect & (target[1:0] != 2'b00);
        load    = redirect & ~bad;
        tgt     = target;
        trap_d  = bad;
        maddr_d = bad ? target : maddr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trap_q  <= 1'b0;
            maddr_q <= '0;
        end else begin
            trap_q  <= trap_d;
            maddr_q <= maddr_d;
        end
    end

    assign misalign_trap = trap_q;
    assign misalign_addr = maddr_q;
`else
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(3));

    always_comb begin
        load = redirect;
        tgt  = target & ALIGN_MASK;
    end

    assign misalign_trap = 1'b0;
    assign misalign_addr = '0;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = load ? tgt : pc_q;
        kill_d     = kill_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (imem_req_ready) begin
                    state_d = S_WAIT;
                    kill_d  = redirect;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    if (kill_q | redirect) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        if_instr_d = imem_rsp_data;
                        if_pc_d    = pc_q;
                        pc_d       = pc_q + XLEN'(4);
                        state_d    = S_HOLD;
                    end
                end else if (redirect) begin
                    kill_d = 1'b1;
                end
            end
            S_HOLD: state_d = (redirect | if_ready) ? S_REQ : S_HOLD;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            kill_q     <= 1'b0;
            if_instr_q <= '0;
            if_pc_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            kill_q     <= kill_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
        end
    end

    assign imem_req_valid = (state_q == S_REQ);
    assign imem_req_addr  = pc_q;
    assign if_valid       = (state_q == S_HOLD);
    assign if_instr       = if_instr_q;
    assign if_pc          = if_pc_q;
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed checks of fetch_pc_unit with a small instruction memory model.
// Memory word for address a is a ^ 32'h1300_0013.
module tb_fetch_pc_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        is_branch = 1'b0, is_jump = 1'b0, taken = 1'b0;
    logic [31:0] target = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        rsp_v = 1'b0, stray_v = 1'b0;
    logic [31:0] rsp_d = '0;
    logic        if_valid;
    logic        if_ready = 1'b1;
    logic [31:0] if_instr, if_pc;
    logic        misalign_trap;
    logic [31:0] misalign_addr;
    logic [31:0] mem_a;
    logic [31:0] g_addr;
    logic        valid_seen = 1'b0;
    int          mem_lat = 1;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    fetch_pc_unit #(.XLEN(32), .RESET_PC(32'h0000_0100)) dut (
        .clk(clk), .rst(rst),
        .is_branch(is_branch), .is_jump(is_jump), .taken(taken), .target(target),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(rsp_v | stray_v), .imem_rsp_data(stray_v ? 32'hDEAD_BEEF : rsp_d),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
        .misalign_trap(misalign_trap), .misalign_addr(misalign_addr)
    );

    initial forever begin
        @(negedge clk);
        if (imem_req_valid && imem_req_ready) begin
            mem_a = imem_req_addr;
            repeat (mem_lat) @(posedge clk);
            #1 rsp_v = 1'b1;
            rsp_d = mem_a ^ 32'h1300_0013;
            @(posedge clk);
            #1 rsp_v = 1'b0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (if_valid) valid_seen = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic fetch_expect(input string tag, input logic [31:0] pc, input logic [31:0] ins);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!if_valid && n < 50);
        check({tag, "_valid"}, {31'b0, if_valid}, 32'd1);
        check({tag, "_pc"}, if_pc, pc);
        check({tag, "_instr"}, if_instr, ins);
    endtask

    task automatic wait_req(input string tag, input logic [31:0] addr);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!imem_req_valid && n < 50);
        check({tag, "_valid"}, {31'b0, imem_req_valid}, 32'd1);
        check({tag, "_addr"}, imem_req_addr, addr);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("rst_if_valid", {31'b0, if_valid}, 32'd0);
        check("rst_pc", imem_req_addr, 32'h0000_0100);
        check("rst_if_instr", if_instr, 32'd0);
        check("rst_if_pc", if_pc, 32'd0);
        check("rst_trap", {31'b0, misalign_trap}, 32'd0);
        check("rst_maddr", misalign_addr, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Sequential fetch from reset
        wait_req("a_req0", 32'h0000_0100);
        fetch_expect("a0", 32'h0000_0100, 32'h1300_0113);
        fetch_expect("a1", 32'h0000_0104, 32'h1300_0117);
        fetch_expect("a2", 32'h0000_0108, 32'h1300_011B);

        // Not-taken branch while waiting
        wait_req("b_req", 32'h0000_010C);
        @(posedge clk);
        #1 is_branch = 1'b1; taken = 1'b0; target = 32'h0000_0200;
        @(posedge clk);
        #1 is_branch = 1'b0;
        fetch_expect("b", 32'h0000_010C, 32'h1300_011F);
        wait_req("b_next", 32'h0000_0110);

        // Taken branch in the cycle the response arrives
        valid_seen = 1'b0;
        @(posedge clk);
        #1 is_branch = 1'b1; taken = 1'b1; target = 32'h0000_0200;
        @(posedge clk);
        #1 is_branch = 1'b0; taken = 1'b0; if_ready = 1'b0;
        @(negedge clk);
        check("c_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("c_req_addr", imem_req_addr, 32'h0000_0200);
        check("c_no_valid", {31'b0, valid_seen}, 32'd0);
        fetch_expect("c", 32'h0000_0200, 32'h1300_0213);

        // Jump in HOLD beats if_ready
        is_jump = 1'b1; target = 32'h0000_0040; if_ready = 1'b1;
        @(posedge clk);
        #1 is_jump = 1'b0;
        @(negedge clk);
        check("d_dropped", {31'b0, if_valid}, 32'd0);
        check("d_req_addr", imem_req_addr, 32'h0000_0040);
        fetch_expect("d", 32'h0000_0040, 32'h1300_0053);

        // Stall in HOLD at the top of memory, PC wraps
        is_jump = 1'b1; target = 32'hFFFF_FFFC;
        @(posedge clk);
        #1 is_jump = 1'b0; if_ready = 1'b0;
        fetch_expect("e", 32'hFFFF_FFFC, 32'hECFF_FFEF);
        for (int i = 0; i < 5; i++) begin
            stray_v = (i == 2);
            @(posedge clk);
            #1 stray_v = 1'b0;
            @(negedge clk);
            check("hold_valid", {31'b0, if_valid}, 32'd1);
            check("hold_pc", if_pc, 32'hFFFF_FFFC);
            check("hold_instr", if_instr, 32'hECFF_FFEF);
            check("hold_no_req", {31'b0, imem_req_valid}, 32'd0);
        end
        check("wrap_pc", imem_req_addr, 32'd0);
        if_ready = 1'b1;
        @(negedge clk);
        check("wrap_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("wrap_req_addr", imem_req_addr, 32'd0);
        fetch_expect("wrap", 32'd0, 32'h1300_0013);

        // Misaligned jump target
        is_jump = 1'b1; target = 32'h0000_0202;
        @(posedge clk);
        #1 is_jump = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        @(negedge clk);
        check("mis_trap", {31'b0, misalign_trap}, 32'd1);
        check("mis_addr", misalign_addr, 32'h0000_0202);
        check("mis_pc", imem_req_addr, 32'h0000_0004);
        @(negedge clk);
        check("mis_trap_off", {31'b0, misalign_trap}, 32'd0);
        check("mis_addr_held", misalign_addr, 32'h0000_0202);
        fetch_expect("mis", 32'h0000_0004, 32'h1300_0017);
        g_addr = 32'h0000_0008;
`else
        @(negedge clk);
        check("mis_trap", {31'b0, misalign_trap}, 32'd0);
        check("mis_addr", imem_req_addr, 32'h0000_0200);
        fetch_expect("mis", 32'h0000_0200, 32'h1300_0213);
        g_addr = 32'h0000_0204;
`endif

        // Redirect before a slow response: response must be killed
        mem_lat = 3;
        wait_req("g_req", g_addr);
        valid_seen = 1'b0;
        @(posedge clk);
        #1 is_branch = 1'b1; taken = 1'b1; target = 32'h0000_0300;
        @(posedge clk);
        #1 is_branch = 1'b0; taken = 1'b0;
        @(negedge clk);
        check("g_waiting", {31'b0, imem_req_valid}, 32'd0);
        check("g_pc", imem_req_addr, 32'h0000_0300);
        wait_req("g_next", 32'h0000_0300);
        check("g_no_valid", {31'b0, valid_seen}, 32'd0);
        fetch_expect("g", 32'h0000_0300, 32'h1300_0313);

        // Reset mid-transaction; stale response lands in IDLE/REQ
        wait_req("h_req", 32'h0000_0304);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("h_rst_req", {31'b0, imem_req_valid}, 32'd0);
        check("h_rst_pc", imem_req_addr, 32'h0000_0100);
        check("h_rst_if_pc", if_pc, 32'd0);
        check("h_rst_instr", if_instr, 32'd0);
        imem_req_ready = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        valid_seen = 1'b0;
        repeat (4) @(negedge clk);
        check("h_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("h_req_addr", imem_req_addr, 32'h0000_0100);
        check("h_no_valid", {31'b0, valid_seen}, 32'd0);
        is_jump = 1'b1; target = 32'h0000_0504;
        @(posedge clk);
        #1 is_jump = 1'b0;
        @(negedge clk);
        check("h_redir_valid", {31'b0, imem_req_valid}, 32'd1);
        check("h_redir_addr", imem_req_addr, 32'h0000_0504);
        @(posedge clk);
        #1 imem_req_ready = 1'b1; mem_lat = 1;
        fetch_expect("h", 32'h0000_0504, 32'h1300_0517);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
